// File: rtl/stage_fetch_pkg.sv
// Shared core definitions for the fetch stage: FSM state type, default
// constants and the PC increment helper.
package stage_fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP           = 32'd4;

   // Sequential successor of a PC, wrapping modulo 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/stage_fetch_pc_register.sv
// Fetch PC register: sequential advance, immediate redirect, and a pending
// redirect slot used while the current request is still being presented.
module pc_register
   import stage_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] target,
   input  logic        req_blocked,
   input  logic        req_accept,
   input  logic        advance,
   output logic [31:0] pc,
   output logic        pend_valid
);

   logic [31:0] pend_target;

   // While a request is blocked the address must stay put, so a redirect is
   // parked and applied on the acceptance edge instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else if (redirect && req_blocked) begin
         pend_valid  <= 1'b1;
         pend_target <= target;
      end else if (redirect) begin
         pc          <= target;
         pend_valid  <= 1'b0;
      end else if (pend_valid && req_accept) begin
         pc          <= pend_target;
         pend_valid  <= 1'b0;
      end else if (advance) begin
         pc          <= pc_next(pc);
      end
   end

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: Avalon-MM read master with a single outstanding
// request, a one-entry return buffer and the IF/DE pipeline register.
module stage_fetch
   import stage_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic        imem_waitrequest,
   input  logic [31:0] imem_readdata,
   input  logic        imem_readdatavalid,
   input  logic        de_stall,
   input  logic        de_clear,
   input  logic        ex_pc_src,
   input  logic [31:0] ex_pc_target,
   output logic [31:0] de_instr,
   output logic [31:0] de_pc,
   output logic [31:0] de_pc_plus4
);

   fetch_state_t state;
   logic         discard;
   logic         buf_valid;
   logic [31:0]  buf_word;
   logic [31:0]  buf_pc;
   logic [31:0]  pc;
   logic         pend_valid;

   logic         in_req;
   logic         in_wait;
   logic         in_hold;
   logic         req_accept;
   logic         req_blocked;
   logic         rdv_wait;
   logic         ready;
   logic         load_word;
   logic         consume;
   logic [31:0]  rdy_word;
   logic [31:0]  rdy_pc;

   assign in_req      = (state == S_REQ);
   assign in_wait     = (state == S_WAIT);
   assign in_hold     = (state == S_HOLD);
   assign req_accept  = in_req && !imem_waitrequest;
   assign req_blocked = in_req && imem_waitrequest;
   assign rdv_wait    = in_wait && imem_readdatavalid;

   // A word is ready from the buffer, or bypassed on its return cycle.
   assign ready     = (in_hold && buf_valid) || (rdv_wait && !discard);
   // A redirect in the same cycle wins over delivering the old-path word.
   assign load_word = ready && !ex_pc_src;
   assign consume   = load_word && !de_stall && !de_clear;
   assign rdy_word  = in_hold ? buf_word : imem_readdata;
   assign rdy_pc    = in_hold ? buf_pc   : pc;

   assign imem_read    = in_req;
   assign imem_address = pc;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (ex_pc_src),
      .target      (ex_pc_target),
      .req_blocked (req_blocked),
      .req_accept  (req_accept),
      .advance     (consume),
      .pc          (pc),
      .pend_valid  (pend_valid)
   );

   // Fetch FSM with discard tracking and the one-entry return buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_REQ;
         discard   <= 1'b0;
         buf_valid <= 1'b0;
         buf_word  <= '0;
         buf_pc    <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (req_accept) begin
                  state   <= S_WAIT;
                  // Request for a stale pc: its data must be dropped.
                  discard <= ex_pc_src || pend_valid;
               end
            end
            S_WAIT: begin
               if (imem_readdatavalid) begin
                  discard <= 1'b0;
                  if (ex_pc_src || discard || consume) begin
                     state <= S_REQ;
                  end else begin
                     state     <= S_HOLD;
                     buf_valid <= 1'b1;
                     buf_word  <= imem_readdata;
                     buf_pc    <= pc;
                  end
               end else if (ex_pc_src) begin
                  discard <= 1'b1;
               end
            end
            S_HOLD: begin
               if (ex_pc_src || consume) begin
                  state     <= S_REQ;
                  buf_valid <= 1'b0;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

   // IF/DE register: clear, then stall, then word, otherwise a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_instr    <= NOP_INSTR;
         de_pc       <= '0;
         de_pc_plus4 <= '0;
      end else if (de_clear) begin
         de_instr    <= NOP_INSTR;
         de_pc       <= '0;
         de_pc_plus4 <= '0;
      end else if (de_stall) begin
         de_instr    <= de_instr;
      end else if (load_word) begin
         de_instr    <= rdy_word;
         de_pc       <= rdy_pc;
         de_pc_plus4 <= pc_next(rdy_pc);
      end else begin
         de_instr    <= NOP_INSTR;
         de_pc       <= '0;
         de_pc_plus4 <= '0;
      end
   end

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch: a memory slave model, a stimulus process
// and a monitor checking the IF/DE stream against the architectural path.
module tb_stage_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_waitrequest = 1'b1;
   logic [31:0] imem_readdata = '0;
   logic        imem_readdatavalid = 1'b0;
   logic        de_stall = 1'b0;
   logic        de_clear = 1'b0;
   logic        ex_pc_src = 1'b0;
   logic [31:0] ex_pc_target = '0;
   logic [31:0] de_instr;
   logic [31:0] de_pc;
   logic [31:0] de_pc_plus4;

   always #5 clk = ~clk;

   stage_fetch #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .imem_read          (imem_read),
      .imem_address       (imem_address),
      .imem_waitrequest   (imem_waitrequest),
      .imem_readdata      (imem_readdata),
      .imem_readdatavalid (imem_readdatavalid),
      .de_stall           (de_stall),
      .de_clear           (de_clear),
      .ex_pc_src          (ex_pc_src),
      .ex_pc_target       (ex_pc_target),
      .de_instr           (de_instr),
      .de_pc              (de_pc),
      .de_pc_plus4        (de_pc_plus4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory contents: distinct per address, never zero, never the NOP word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b10} ^ 32'h5A5A_0000;
   endfunction

   // Expected next pc on the architectural path (reference model state).
   logic [31:0] exp_q[$];

   // Memory slave model knobs and logs.
   int          resp_cnt = 0;
   logic [31:0] resp_addr = '0;
   bit          rand_wait = 1'b0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   logic [31:0] slow_addr = 32'hFFFF_FFFF;
   int          slow_lat = 3;
   logic [31:0] fw_addr = 32'h0000_0010;
   int          fw_left = 0;
   int          fw_seen = 0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_addr = '0;
   bit          acc_now = 1'b0;
   logic [31:0] acc_log[$];

   // Avalon slave: one response per accepted read, data after lat cycles.
   always begin
      @(posedge clk);
      #2;
      acc_now = 1'b0;
      imem_readdatavalid = 1'b0;
      imem_readdata = $urandom;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            imem_readdatavalid = 1'b1;
            imem_readdata = mem_word(resp_addr);
         end
      end
      if (rst_n && prev_hold) begin
         chk("held_read", 32'(imem_read), 32'd1);
         chk("held_addr", imem_address, prev_addr);
      end
      if (!rst_n || resp_cnt > 0) begin
         imem_waitrequest = 1'b1;
      end else if (imem_read && imem_address == fw_addr && fw_left > 0) begin
         imem_waitrequest = 1'b1;
         fw_left--;
         fw_seen++;
      end else begin
         imem_waitrequest = rand_wait ? ($urandom_range(3) == 0) : 1'b0;
      end
      if (rst_n && imem_read && !imem_waitrequest) begin
         resp_addr = imem_address;
         resp_cnt  = (imem_address == slow_addr) ? slow_lat : int'($urandom_range(lat_hi, lat_lo));
         acc_now   = 1'b1;
         acc_log.push_back(imem_address);
      end
      prev_hold = rst_n && imem_read && imem_waitrequest;
      prev_addr = imem_address;
   end

   // Monitor: classify each edge by its inputs and compare the IF/DE register.
   int          cyc = 0;
   int          n_load = 0;
   int          load_cyc[$];
   logic [31:0] last_i = '0;
   logic [31:0] last_p = '0;
   logic [31:0] last_p4 = '0;

   always begin : mon
      logic [31:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         chk("rst_instr", de_instr, NOP);
         chk("rst_pc", de_pc, 32'd0);
         chk("rst_pc4", de_pc_plus4, 32'd0);
         chk("rst_read", 32'(imem_read), 32'd1);
         chk("rst_addr", imem_address, RST_PC);
      end else if (de_clear) begin
         chk("clr_instr", de_instr, NOP);
         chk("clr_pc", de_pc, 32'd0);
         chk("clr_pc4", de_pc_plus4, 32'd0);
      end else if (de_stall) begin
         chk("stall_instr", de_instr, last_i);
         chk("stall_pc", de_pc, last_p);
         chk("stall_pc4", de_pc_plus4, last_p4);
      end else if (ex_pc_src) begin
         chk("redir_instr", de_instr, NOP);
         chk("redir_pc", de_pc, 32'd0);
         chk("redir_pc4", de_pc_plus4, 32'd0);
      end else if (de_instr == NOP) begin
         chk("bub_pc", de_pc, 32'd0);
         chk("bub_pc4", de_pc_plus4, 32'd0);
      end else begin
         chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("de_pc", de_pc, e);
            chk("de_instr", de_instr, mem_word(e));
            chk("de_pc4", de_pc_plus4, e + 32'd4);
            exp_q.push_back(e + 32'd4);
         end
         n_load++;
         load_cyc.push_back(cyc);
      end
      last_i  = de_instr;
      last_p  = de_pc;
      last_p4 = de_pc_plus4;
   end

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic drive(input bit st, input bit cl, input bit rd, input logic [31:0] tg);
      de_stall     = st;
      de_clear     = cl;
      ex_pc_src    = rd;
      ex_pc_target = tg;
      if (rd) begin
         exp_q.delete();
         exp_q.push_back(tg);
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0);
      exp_q.delete();
      exp_q.push_back(RST_PC);
      load_cyc.delete();
      repeat (n) step();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          found;
      int          base;
      logic [31:0] tg;
      bit          r;

      step();
      do_reset(2);

      // Zero-wait memory, waitrequest held 3 cycles on the request for 0x10.
      fw_left = 3;
      for (int i = 0; i < 80 && load_cyc.size() < 6; i++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, '0);
      end
      chk("seq_loads", 32'(load_cyc.size() >= 6), 32'd1);
      if (load_cyc.size() >= 6) begin
         chk("gap_0_4", 32'(load_cyc[1] - load_cyc[0]), 32'd2);
         chk("gap_4_8", 32'(load_cyc[2] - load_cyc[1]), 32'd2);
         chk("gap_c_10", 32'(load_cyc[4] - load_cyc[3]), 32'd5);
      end
      chk("wait_cycles_0x10", 32'(fw_seen), 32'd3);

      // Redirect to 0x200 while the read for 0x20 is outstanding.
      slow_addr = 32'h0000_0020;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, '0);
         found = acc_now && (acc_log[$] == 32'h0000_0020);
      end
      chk("acc_0x20", 32'(found), 32'd1);
      step();
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0200);
      base = acc_log.size();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, '0);
         found = acc_log.size() > base;
      end
      chk("acc_after_redir", 32'(found), 32'd1);
      if (found) chk("addr_after_redir", acc_log[base], 32'h0000_0200);
      slow_addr = 32'hFFFF_FFFF;

      // Stall for 4 cycles while a word is captured and buffered.
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, '0);
         found = acc_now;
      end
      chk("acc_stall", 32'(found), 32'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, '0);
         chk("stall_no_read", 32'(imem_read), 32'd0);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      base = n_load;
      step();
      chk("release_load", 32'(n_load - base), 32'd1);

      // Reset while a slow read is outstanding; its data arrives after reset.
      lat_lo = 3;
      lat_hi = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, '0);
         found = acc_now;
      end
      chk("acc_rst", 32'(found), 32'd1);
      step();
      base = acc_log.size();
      do_reset(1);
      lat_lo = 1;
      lat_hi = 1;
      step();
      step();
      chk("stray_ignored", de_instr, NOP);
      chk("acc_post_rst", 32'(acc_log.size() > base), 32'd1);
      if (acc_log.size() > base) chk("addr_post_rst", acc_log[base], RST_PC);

      // Fetch across the top of the address space.
      base = acc_log.size();
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 24; i++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, '0);
      end
      found = 1'b0;
      for (int i = base; i + 1 < acc_log.size() && !found; i++) begin
         if (acc_log[i] == 32'hFFFF_FFFC) begin
            found = 1'b1;
            chk("wrap_next_addr", acc_log[i+1], 32'h0000_0000);
         end
      end
      chk("wrap_seen", 32'(found), 32'd1);

      // Randomised traffic: waitrequest, latency, stalls, clears, redirects.
      rand_wait = 1'b1;
      lat_lo = 1;
      lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (i == 1500) begin
            do_reset(2);
         end else begin
            r  = ($urandom_range(19) == 0);
            tg = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'h0000_000C);
            drive($urandom_range(6) == 0,
                  r ? ($urandom_range(4) != 0) : ($urandom_range(12) == 0),
                  r, tg);
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      repeat (5) step();
      chk("loads_seen", 32'(n_load > 100), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
